csr_neighbor_fetch: RTL

//  Upstream request engine for graph_memory (CSR store: ptr_mem = row-index pointers, data_mem = neighbour list).

---
 rtl/csr_neighbor_fetch_pkg.sv | 27 ++
 rtl/csr_neighbor_fetch_if.sv | 42 ++++
 rtl/csr_neighbor_fetch_fifo_2w.sv | 59 +++++
 rtl/csr_neighbor_fetch.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/csr_neighbor_fetch_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | csr_fetch_pkg : shared types for the CSR neighbour fetch engine          |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package csr_fetch_pkg;

    localparam int ADDR_W = 32;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PTR0   = 3'd1,
        PTR1   = 3'd2,
        PTRW   = 3'd3,
        STREAM = 3'd4,
        NONE   = 3'd5,
        DRAIN  = 3'd6
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
        logic        none;
    } beat_t;

endpackage
`default_nettype wire

// File: rtl/csr_neighbor_fetch_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | csr_neighbor_fetch_if : request, graph_memory and neighbour stream bus   |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface csr_neighbor_fetch_if #(
    parameter int PROC_BITS = 4
);
    import csr_fetch_pkg::*;

    logic                        req_valid;
    logic [31:0]                 req_vid;
    logic                        req_ready;
    logic [ADDR_W+PROC_BITS-1:0] idx_addr;
    logic                        idx_validin;
    logic [31:0]                 rowidx_in;
    logic [ADDR_W+PROC_BITS-1:0] data_addra;
    logic                        data_validina;
    logic [ADDR_W+PROC_BITS-1:0] data_addrb;
    logic                        data_validinb;
    logic [31:0]                 data_ina;
    logic [31:0]                 data_inb;
    logic                        out_valid;
    logic [31:0]                 out_data;
    logic                        out_last;
    logic                        out_none;
    logic                        out_ready;

    modport master (
        input  req_valid, req_vid, rowidx_in, data_ina, data_inb, out_ready,
        output req_ready, idx_addr, idx_validin, data_addra, data_validina,
               data_addrb, data_validinb, out_valid, out_data, out_last, out_none
    );

    modport slave (
        output req_valid, req_vid, rowidx_in, data_ina, data_inb, out_ready,
        input  req_ready, idx_addr, idx_validin, data_addra, data_validina,
               data_addrb, data_validinb, out_valid, out_data, out_last, out_none
    );

endinterface
`default_nettype wire

// File: rtl/csr_neighbor_fetch_fifo_2w.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_fifo_2w : beat FIFO, two ordered pushes (A then B), one pop        |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module fetch_fifo_2w
    import csr_fetch_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     push_a,
    input  beat_t                    beat_a,
    input  logic                     push_b,
    input  beat_t                    beat_b,
    input  logic                     pop,
    output beat_t                    head,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    beat_t           mem_q [DEPTH];
    beat_t           mem_d [DEPTH];
    logic [AW-1:0]   wr_q, wr_d, rd_q, rd_d, wr_b;
    logic [AW:0]     cnt_q, cnt_d;

    always_comb begin
        mem_d = mem_q;
        wr_b  = push_a ? wr_q + AW'(1) : wr_q;
        if (push_a) mem_d[wr_q] = beat_a;
        if (push_b) mem_d[wr_b] = beat_b;
        wr_d  = wr_q + AW'(push_a) + AW'(push_b);
        rd_d  = rd_q + AW'(pop);
        cnt_d = cnt_q + (AW+1)'(push_a) + (AW+1)'(push_b) - (AW+1)'(pop);
    end

    // Storage needs no reset; only the pointers define emptiness.
    always_ff @(posedge clk_in) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    assign head  = mem_q[rd_q];
    assign count = cnt_q;

endmodule
`default_nettype wire

// File: rtl/csr_neighbor_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | csr_neighbor_fetch : reads CSR row pointers, streams neighbour words     |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module csr_neighbor_fetch
    import csr_fetch_pkg::*;
#(
    parameter int PROC_BITS  = 4,
    parameter int PROC_ID    = 0,
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    csr_neighbor_fetch_if.master bus
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int CRD_W = CNT_W + 1;

    localparam logic [2:0] S_IDLE   = IDLE;
    localparam logic [2:0] S_PTR0   = PTR0;
    localparam logic [2:0] S_PTR1   = PTR1;
    localparam logic [2:0] S_PTRW   = PTRW;
    localparam logic [2:0] S_STREAM = STREAM;
    localparam logic [2:0] S_NONE   = NONE;
    localparam logic [2:0] S_DRAIN  = DRAIN;

    logic [2:0]                 state_q, state_d;
    logic [31:0]                vid_q, vid_d, start_q, start_d;
    logic [31:0]                cur_q, cur_d, rem_q, rem_d;
    logic [CRD_W-1:0]           inflight_q, inflight_d, credits;
    logic                       rdy_q, rdy_d;
    logic [RD_LAT-1:0][1:0]     ptr_pipe_q, ptr_pipe_d;
    logic [RD_LAT-1:0][3:0]     ret_pipe_q, ret_pipe_d;

    logic [1:0]        ptr_ret;
    logic [3:0]        ret;
    logic              idx_v, a_v, b_v, la, lb, none_push;
    logic [31:0]       idx_lo, a_addr, b_addr;
    logic              push_a, push_b, pop;
    beat_t             beat_a, beat_b, fifo_head;
    logic [CNT_W-1:0]  fifo_count;

    // ptr_ret = {pointer1, pointer0}; ret = {vA, vB, lastA, lastB}
    assign ptr_ret = ptr_pipe_q[RD_LAT-1];
    assign ret     = ret_pipe_q[RD_LAT-1];
    assign credits = CRD_W'(FIFO_DEPTH) - CRD_W'(fifo_count) - inflight_q;

    always_comb begin
        state_d   = state_q;
        vid_d     = vid_q;
        start_d   = start_q;
        cur_d     = cur_q;
        rem_d     = rem_q;
        rdy_d     = 1'b1;
        idx_v     = 1'b0;
        idx_lo    = '0;
        a_v       = 1'b0;
        b_v       = 1'b0;
        la        = 1'b0;
        lb        = 1'b0;
        a_addr    = '0;
        b_addr    = '0;
        none_push = 1'b0;

        if (ptr_ret[0]) start_d = bus.rowidx_in;

        case (state_q)
            S_IDLE: begin
                if (bus.req_valid && rdy_q) begin
                    vid_d   = bus.req_vid;
                    state_d = S_PTR0;
                end
            end
            S_PTR0: begin
                idx_v   = 1'b1;
                idx_lo  = vid_q;
                state_d = S_PTR1;
            end
            S_PTR1: begin
                idx_v   = 1'b1;
                idx_lo  = vid_q + 32'd1;
                state_d = S_PTRW;
            end
            S_PTRW: begin
                // End pointer is used straight off the return bus.
                if (ptr_ret[1]) begin
                    cur_d   = start_q;
                    rem_d   = bus.rowidx_in - start_q;
                    state_d = (bus.rowidx_in > start_q) ? S_STREAM : S_NONE;
                end
            end
            S_STREAM: begin
                if (rem_q == 32'd0) begin
                    state_d = S_DRAIN;
                end else if (rem_q >= 32'd2 && credits >= CRD_W'(2)) begin
                    a_v    = 1'b1;
                    b_v    = 1'b1;
                    a_addr = cur_q;
                    b_addr = cur_q + 32'd1;
                    lb     = (rem_q == 32'd2);
                    cur_d  = cur_q + 32'd2;
                    rem_d  = rem_q - 32'd2;
                end else if (rem_q == 32'd1 && credits >= CRD_W'(1)) begin
                    a_v    = 1'b1;
                    a_addr = cur_q;
                    la     = 1'b1;
                    cur_d  = cur_q + 32'd1;
                    rem_d  = 32'd0;
                end
            end
            S_NONE: begin
                none_push = 1'b1;
                state_d   = S_DRAIN;
            end
            S_DRAIN: begin
                if (fifo_count == '0 && inflight_q == '0) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        inflight_d = inflight_q + CRD_W'(a_v) + CRD_W'(b_v)
                   - CRD_W'(ret[3]) - CRD_W'(ret[2]);

        ptr_pipe_d[0] = {state_q == S_PTR1, state_q == S_PTR0};
        ret_pipe_d[0] = {a_v, b_v, la, lb};
        for (int i = 1; i < RD_LAT; i++) begin
            ptr_pipe_d[i] = ptr_pipe_q[i-1];
            ret_pipe_d[i] = ret_pipe_q[i-1];
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q    <= S_IDLE;
            vid_q      <= '0;
            start_q    <= '0;
            cur_q      <= '0;
            rem_q      <= '0;
            inflight_q <= '0;
            rdy_q      <= 1'b0;
            ptr_pipe_q <= '0;
            ret_pipe_q <= '0;
        end else begin
            state_q    <= state_d;
            vid_q      <= vid_d;
            start_q    <= start_d;
            cur_q      <= cur_d;
            rem_q      <= rem_d;
            inflight_q <= inflight_d;
            rdy_q      <= rdy_d;
            ptr_pipe_q <= ptr_pipe_d;
            ret_pipe_q <= ret_pipe_d;
        end
    end

    assign push_a = ret[3] | none_push;
    assign push_b = ret[2];
    assign beat_a = none_push ? '{data: 32'd0, last: 1'b1, none: 1'b1}
                              : '{data: bus.data_ina, last: ret[1], none: 1'b0};
    assign beat_b = '{data: bus.data_inb, last: ret[0], none: 1'b0};
    assign pop    = bus.out_valid && bus.out_ready;

    fetch_fifo_2w #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .push_a (push_a),
        .beat_a (beat_a),
        .push_b (push_b),
        .beat_b (beat_b),
        .pop    (pop),
        .head   (fifo_head),
        .count  (fifo_count)
    );

    assign bus.req_ready     = (state_q == S_IDLE) && rdy_q;
    assign bus.idx_validin   = idx_v;
    assign bus.idx_addr      = idx_v ? {PROC_BITS'(PROC_ID), idx_lo} : '0;
    assign bus.data_validina = a_v;
    assign bus.data_addra    = a_v ? {PROC_BITS'(PROC_ID), a_addr} : '0;
    assign bus.data_validinb = b_v;
    assign bus.data_addrb    = b_v ? {PROC_BITS'(PROC_ID), b_addr} : '0;
    assign bus.out_valid     = (fifo_count != '0);
    assign bus.out_data      = fifo_head.data;
    assign bus.out_last      = fifo_head.last;
    assign bus.out_none      = fifo_head.none;

endmodule
`default_nettype wire
